// File: rtl/oflow_score_board_responder.sv
// oflow_score_board_responder: assigns object IDs per PE slot and writes them into the score-board row memory; OFLOW_SCORE_BOARD_STATS_EN adds allocation/match counters
module oflow_score_board_responder #(
  parameter int PE_NUM = 8,
  parameter int ROW_LEN = 5,
  parameter int ID_LEN = 12,
  parameter int SCORE_W = 16,
  localparam int SL = $clog2(PE_NUM)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start_score_board,
  input  logic                        first_frame,
  input  logic [ROW_LEN-1:0]          row_sel_by_set,
  input  logic [ID_LEN-1:0]           id_first_frame,
  input  logic [PE_NUM-1:0]           pe_valid,
  input  logic [PE_NUM*SCORE_W-1:0]   score_vec,
  input  logic [PE_NUM*ID_LEN-1:0]    match_id_vec,
  input  logic [SCORE_W-1:0]          score_thr,
  output logic                        done_score_board,
  output logic                        busy,
  output logic                        wr_en,
  output logic [ROW_LEN+SL-1:0]       wr_addr,
  output logic [ID_LEN-1:0]           wr_data,
  output logic                        req_drop
`ifdef OFLOW_SCORE_BOARD_STATS_EN
  ,
  output logic [15:0]                 stat_new_cnt,
  output logic [15:0]                 stat_match_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state, state_n;
  logic [SL-1:0] slot;
  logic ff_q;
  logic [ROW_LEN-1:0] row_q;
  logic [ID_LEN-1:0] base_q, next_id, cur_mid, ff_end;
  logic [PE_NUM-1:0] valid_q;
  logic [PE_NUM*SCORE_W-1:0] score_q;
  logic [PE_NUM*ID_LEN-1:0] mid_q;
  logic [SCORE_W-1:0] thr_q, cur_score;
  logic last, is_match, alloc, matched;
  // state register; reset aborts any set in flight without a done
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  // next state and all combinational outputs, so reset drops them immediately
  always_comb begin
    state_n = state == IDLE ? (start_score_board ? SCAN : IDLE) : state == SCAN ? (last ? DONE : SCAN) : IDLE;
    cur_score = score_q[slot*SCORE_W +: SCORE_W];
    cur_mid = mid_q[slot*ID_LEN +: ID_LEN];
    last = slot == SL'(PE_NUM-1);
    is_match = cur_score <= thr_q && cur_mid != '0;
    wr_en = state == SCAN && valid_q[slot];
    alloc = wr_en && !ff_q && !is_match;
    matched = wr_en && !ff_q && is_match;
    wr_data = wr_en ? (ff_q ? base_q + ID_LEN'(slot) : is_match ? cur_mid : next_id) : '0;
    wr_addr = wr_en ? {row_q, slot} : '0;
    done_score_board = state == DONE;
    busy = state != IDLE;
    ff_end = base_q + ID_LEN'(PE_NUM);
  end
  // request latch, slot walk, new-ID allocator (never yields 0) and sticky drop flag
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      slot <= '0;
      ff_q <= 1'b0;
      row_q <= '0;
      base_q <= '0;
      valid_q <= '0;
      score_q <= '0;
      mid_q <= '0;
      thr_q <= '0;
      next_id <= ID_LEN'(1);
      req_drop <= 1'b0;
    end else begin
      if (start_score_board && state == IDLE) begin
        slot <= '0;
        ff_q <= first_frame;
        row_q <= row_sel_by_set;
        base_q <= id_first_frame;
        valid_q <= pe_valid;
        score_q <= score_vec;
        mid_q <= match_id_vec;
        thr_q <= score_thr;
      end
      if (start_score_board && state != IDLE) req_drop <= 1'b1;
      if (state == SCAN) slot <= last ? '0 : slot + SL'(1);
      if (alloc) next_id <= next_id == '1 ? ID_LEN'(1) : next_id + ID_LEN'(1);
      if (state == SCAN && last && ff_q) next_id <= ff_end == '0 ? ID_LEN'(1) : ff_end;
    end
`ifdef OFLOW_SCORE_BOARD_STATS_EN
  // saturating counters of new-ID allocations and threshold matches
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      stat_new_cnt <= '0;
      stat_match_cnt <= '0;
    end else begin
      if (alloc && stat_new_cnt != '1) stat_new_cnt <= stat_new_cnt + 16'd1;
      if (matched && stat_match_cnt != '1) stat_match_cnt <= stat_match_cnt + 16'd1;
    end
`endif
endmodule
